// File: rtl/gslcd_timing_gen_pkg.sv
// gslcd_timing_gen_pkg: default 800x480 panel timing and shared types
package gslcd_timing_gen_pkg;
  localparam int LCD_LINE_REG_WIDTH  = 10;
  localparam int LCD_PIXEL_REG_WIDTH = 10;
  localparam int LCD_LINES           = 525;
  localparam int LCD_VSYNC_START     = 13;
  localparam int LCD_VSYNC_END       = 16;
  localparam int LCD_VACTIVE_START   = 45;
  localparam int LCD_HPIXELS         = 928;
  localparam int LCD_HSYNC_START     = 40;
  localparam int LCD_HSYNC_END       = 88;
  localparam int LCD_HACTIVE_START   = 128;
  localparam int FRAME_W             = LCD_HPIXELS - LCD_HACTIVE_START;
  localparam int FRAME_H             = LCD_LINES - LCD_VACTIVE_START;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/gslcd_timing_gen_if.sv
// gslcd_timing_gen_if: panel timing bundle between generator and pixel fetch/panel pins
interface gslcd_timing_gen_if #(
  parameter int PIXEL_W = 10,
  parameter int LINE_W  = 10
);
  logic               en;
  logic               vsync;
  logic               hsync;
  logic               active;
  logic               frame_start;
  logic [PIXEL_W-1:0] pixel;
  logic [LINE_W-1:0]  line;
  modport master (input en, output vsync, hsync, active, frame_start, pixel, line);
  modport slave  (output en, input vsync, hsync, active, frame_start, pixel, line);
endinterface

// File: rtl/gslcd_timing_gen.sv
// gslcd_timing_gen: free-running raster timing generator (H/V sync, DE, frame start, position)
module gslcd_timing_gen
  import gslcd_timing_gen_pkg::*;
#(
  parameter int C_LCD_LINE_REG_WIDTH  = LCD_LINE_REG_WIDTH,
  parameter int C_LCD_PIXEL_REG_WIDTH = LCD_PIXEL_REG_WIDTH,
  parameter int C_LCD_LINES           = LCD_LINES,
  parameter int C_LCD_VSYNC_START     = LCD_VSYNC_START,
  parameter int C_LCD_VSYNC_END       = LCD_VSYNC_END,
  parameter int C_LCD_VACTIVE_START   = LCD_VACTIVE_START,
  parameter int C_LCD_HPIXELS         = LCD_HPIXELS,
  parameter int C_LCD_HSYNC_START     = LCD_HSYNC_START,
  parameter int C_LCD_HSYNC_END       = LCD_HSYNC_END,
  parameter int C_LCD_HACTIVE_START   = LCD_HACTIVE_START
) (
  input logic                 pclk,
  input logic                 presetn,
  gslcd_timing_gen_if.master  lcd
);
  localparam int PW = C_LCD_PIXEL_REG_WIDTH;
  localparam int LW = C_LCD_LINE_REG_WIDTH;
  localparam logic [PW-1:0] P_LAST = PW'(C_LCD_HPIXELS - 1);
  localparam logic [PW-1:0] HS_S   = PW'(C_LCD_HSYNC_START);
  localparam logic [PW-1:0] HS_E   = PW'(C_LCD_HSYNC_END);
  localparam logic [PW-1:0] HA_S   = PW'(C_LCD_HACTIVE_START);
  localparam logic [LW-1:0] L_LAST = LW'(C_LCD_LINES - 1);
  localparam logic [LW-1:0] VS_S   = LW'(C_LCD_VSYNC_START);
  localparam logic [LW-1:0] VS_E   = LW'(C_LCD_VSYNC_END);
  localparam logic [LW-1:0] VA_S   = LW'(C_LCD_VACTIVE_START);
  if (!(C_LCD_HSYNC_START < C_LCD_HSYNC_END && C_LCD_HSYNC_END <= C_LCD_HACTIVE_START &&
        C_LCD_HACTIVE_START < C_LCD_HPIXELS && 2**PW > C_LCD_HPIXELS - 1)) begin : g_bad_h
    $error("gslcd_timing_gen: inconsistent horizontal timing or pixel counter width");
  end
  if (!(C_LCD_VSYNC_START < C_LCD_VSYNC_END && C_LCD_VSYNC_END <= C_LCD_VACTIVE_START &&
        C_LCD_VACTIVE_START < C_LCD_LINES && 2**LW > C_LCD_LINES - 1)) begin : g_bad_v
    $error("gslcd_timing_gen: inconsistent vertical timing or line counter width");
  end
  state_t          state_q, state_nxt;
  logic [PW-1:0]   pix_q, pix_nxt;
  logic [LW-1:0]   line_q, line_nxt;
  logic            hs_nxt, vs_nxt, act_nxt, fs_nxt;
  logic            hold, pix_end;
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_nxt;
      pix_q   <= pix_nxt;
      line_q  <= line_nxt;
    end
  end
  // position is held at the origin until the cycle after EN is seen, so the first running cycle is (0,0)
  always_comb begin
    state_nxt = lcd.en ? ST_RUN : ST_IDLE;
    hold      = !lcd.en || state_q == ST_IDLE;
    pix_end   = pix_q == P_LAST;
    pix_nxt   = (hold || pix_end) ? '0 : pix_q + 1'b1;
    line_nxt  = hold ? '0 : !pix_end ? line_q : (line_q == L_LAST) ? '0 : line_q + 1'b1;
  end
  // decode from next state so registered outputs line up with the registered position
  always_comb begin
    hs_nxt  = !(state_nxt == ST_RUN && pix_nxt >= HS_S && pix_nxt < HS_E);
    vs_nxt  = !(state_nxt == ST_RUN && line_nxt >= VS_S && line_nxt < VS_E);
    act_nxt = state_nxt == ST_RUN && line_nxt >= VA_S && pix_nxt >= HA_S;
    fs_nxt  = state_nxt == ST_RUN && line_nxt == '0 && pix_nxt == '0;
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      lcd.hsync       <= 1'b1;
      lcd.vsync       <= 1'b1;
      lcd.active      <= 1'b0;
      lcd.frame_start <= 1'b0;
    end else begin
      lcd.hsync       <= hs_nxt;
      lcd.vsync       <= vs_nxt;
      lcd.active      <= act_nxt;
      lcd.frame_start <= fs_nxt;
    end
  end
  assign lcd.pixel = pix_q;
  assign lcd.line  = line_q;
endmodule

// File: tb/tb_gslcd_timing_gen.sv
// tb_gslcd_timing_gen: directed checks on a shrunken 20x12 raster
module tb_gslcd_timing_gen;
  localparam int HP = 20, LN = 12;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  int checks = 0, errors = 0;
  int ex_p, ex_l, hs_low, vs_low, act_cnt, fs_cnt, hs_run, hs_first;
  gslcd_timing_gen_if #(.PIXEL_W(5), .LINE_W(4)) lcd ();
  gslcd_timing_gen #(
    .C_LCD_LINE_REG_WIDTH(4), .C_LCD_PIXEL_REG_WIDTH(5), .C_LCD_LINES(LN),
    .C_LCD_VSYNC_START(2), .C_LCD_VSYNC_END(5), .C_LCD_VACTIVE_START(5),
    .C_LCD_HPIXELS(HP), .C_LCD_HSYNC_START(3), .C_LCD_HSYNC_END(7), .C_LCD_HACTIVE_START(8)
  ) dut (.pclk(pclk), .presetn(presetn), .lcd(lcd));
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge pclk);
    @(negedge pclk);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_hs"}, lcd.hsync, 1);
    chk({tag, "_vs"}, lcd.vsync, 1);
    chk({tag, "_act"}, lcd.active, 0);
    chk({tag, "_fs"}, lcd.frame_start, 0);
    chk({tag, "_pix"}, lcd.pixel, 0);
    chk({tag, "_line"}, lcd.line, 0);
  endtask
  initial begin
    lcd.en = 1'b0;
    #12;
    chk_idle("reset");
    presetn = 1'b1;
    step();
    chk_idle("en_low");
    lcd.en = 1'b1;
    step();
    chk("first_fs", lcd.frame_start, 1);
    chk("first_pix", lcd.pixel, 0);
    chk("first_line", lcd.line, 0);
    ex_p = 0; ex_l = 0; hs_low = 0; vs_low = 0; act_cnt = 0; fs_cnt = 0; hs_run = 0; hs_first = -1;
    for (int i = 0; i < HP * LN; i++) begin
      if (lcd.pixel != 5'(ex_p) || lcd.line != 4'(ex_l)) chk("pos", int'(lcd.line) * 100 + int'(lcd.pixel), ex_l * 100 + ex_p);
      hs_low  += int'(!lcd.hsync);
      vs_low  += int'(!lcd.vsync);
      act_cnt += int'(lcd.active);
      fs_cnt  += int'(lcd.frame_start);
      if (ex_l == 1 && !lcd.hsync) begin
        hs_run++;
        if (hs_first < 0) hs_first = ex_p;
      end
      if (ex_l == 3 && ex_p == 0)  chk("vs_line3_hblank", lcd.vsync, 0);
      if (ex_l == 4 && ex_p == 19) chk("vs_line4_end", lcd.vsync, 0);
      if (ex_l == 5 && ex_p == 0)  chk("vs_line5", lcd.vsync, 1);
      if (ex_l == 5 && ex_p == 7)  chk("act_5_7", lcd.active, 0);
      if (ex_l == 5 && ex_p == 8)  chk("act_5_8", lcd.active, 1);
      if (ex_l == 4 && ex_p == 8)  chk("act_4_8", lcd.active, 0);
      if (ex_l == 11 && ex_p == 19) chk("act_11_19", lcd.active, 1);
      if (ex_l == 7 && ex_p == 2)  chk("hs_p2", lcd.hsync, 1);
      if (ex_l == 7 && ex_p == 3)  chk("hs_p3", lcd.hsync, 0);
      if (ex_l == 7 && ex_p == 6)  chk("hs_p6", lcd.hsync, 0);
      if (ex_l == 7 && ex_p == 7)  chk("hs_p7", lcd.hsync, 1);
      step();
      ex_p++;
      if (ex_p == HP) begin
        ex_p = 0;
        ex_l = (ex_l == LN - 1) ? 0 : ex_l + 1;
      end
    end
    chk("hs_low_total", hs_low, 4 * LN);
    chk("hs_run_line1", hs_run, 4);
    chk("hs_first_pix", hs_first, 3);
    chk("vs_low_total", vs_low, 3 * HP);
    chk("act_total", act_cnt, 7 * 12);
    chk("fs_per_frame", fs_cnt, 1);
    chk("wrap_fs", lcd.frame_start, 1);
    chk("wrap_pix", lcd.pixel, 0);
    chk("wrap_line", lcd.line, 0);
    for (int i = 0; i < 2 * HP * LN && !(lcd.line == 4'd6 && lcd.pixel == 5'd10); i++) step();
    chk("reach_l6", lcd.line, 6);
    lcd.en = 1'b0;
    step();
    chk_idle("abort");
    lcd.en = 1'b1;
    step();
    chk("reen_fs", lcd.frame_start, 1);
    chk("reen_pix", lcd.pixel, 0);
    step();
    chk("reen_fs_drop", lcd.frame_start, 0);
    chk("reen_pix1", lcd.pixel, 1);
    for (int i = 0; i < 100; i++) step();
    chk("pre_rst_line", lcd.line, 5);
    @(posedge pclk);
    #2 presetn = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge pclk);
    presetn = 1'b1;
    step();
    chk("rst_fs", lcd.frame_start, 1);
    chk("rst_pix", lcd.pixel, 0);
    chk("rst_line", lcd.line, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
